sram_mem_ctrl: RTL and testbench

//  MEM-stage responder for the load/store requests the decoder raises (mem_r_en/mem_w_en).

---
 rtl/sram_mem_ctrl_if.sv | 21 ++
 rtl/sram_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_ctrl_if.sv
// CPU-side load/store bus between the EXE/MEM pipeline register and the
// SRAM controller. The pipeline is the master; the controller is the slave.
interface sram_mem_ctrl_if;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        ready;
   logic        freeze;

   modport master (
      output mem_r_en, mem_w_en, addr, wr_data,
      input  rd_data, ready, freeze
   );

   modport slave (
      input  mem_r_en, mem_w_en, addr, wr_data,
      output rd_data, ready, freeze
   );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage SRAM controller: each 32-bit word access becomes two 16-bit SRAM
// phases (low half, then high half) of WAIT_CYCLES clocks each, and the
// pipeline is frozen until the word completes.
// Optional feature macro: SRAM_ADDR_CHECK_EN -- requests below BASE_ADDR or
// beyond the SRAM word range complete in one cycle with no SRAM activity.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for mem_r_en/mem_w_en; latches op, word and store data
// LO    | low halfword phase, sram_addr = {word,0}, WAIT_CYCLES clocks
// HI    | high halfword phase, sram_addr = {word,1}, WAIT_CYCLES clocks
// DONE  | one-cycle ready pulse, rd_data stable
module sram_mem_ctrl #(
   parameter int WAIT_CYCLES = 5,
   parameter int BASE_ADDR   = 1024,
   parameter int ADDR_W      = 18
) (
   input  logic                clk,
   input  logic                rst_n,
   sram_mem_ctrl_if.slave      bus,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [15:0]         sram_dq_o,
   input  logic [15:0]         sram_dq_i,
   output logic                sram_dq_oe,
   output logic                sram_we_n
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [31:0]      BASE_W   = 32'(BASE_ADDR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-2:0] word_q, word_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]       dq_o_q, dq_o_d;
   logic              oe_q, oe_d;
   logic              we_n_q, we_n_d;

   logic              req;
   logic              ready;
   logic              last_cyc;
   logic              phase_d;
   logic [31:0]       diff;
   logic              unused_diff;

   assign req      = bus.mem_r_en | bus.mem_w_en;
   assign ready    = (state_q == S_DONE);
   assign last_cyc = (cnt_q == CNT_LAST);
   // Byte offset from the SRAM window; the word index is diff[ADDR_W:2], the
   // bits above it only matter to the range check and the byte lanes are ignored.
   assign diff        = bus.addr - BASE_W;
   assign unused_diff = ^{diff[1:0], diff[31:ADDR_W+1]};

`ifdef SRAM_ADDR_CHECK_EN
   logic addr_bad;
   assign addr_bad = (bus.addr < BASE_W) || (|diff[31:ADDR_W+1]);
`endif

   assign bus.ready   = ready;
   assign bus.freeze  = req & ~ready;
   assign bus.rd_data = rd_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_o   = dq_o_q;
   assign sram_dq_oe  = oe_q;
   assign sram_we_n   = we_n_q;

   // Next state, phase counter, latched request and read capture; SRAM pin
   // values are derived from the next state so the pins come straight off flops.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_wr_d   = op_wr_q;
      word_d    = word_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_wr_d = bus.mem_w_en;
               word_d  = diff[ADDR_W:2];
               wdata_d = bus.wr_data;
               cnt_d   = '0;
               state_d = S_LO;
`ifdef SRAM_ADDR_CHECK_EN
               if (addr_bad) begin
                  state_d = S_DONE;
                  if (!bus.mem_w_en) rd_data_d = '0;
               end
`endif
            end
         end
         S_LO: begin
            if (last_cyc) begin
               if (!op_wr_q) rd_data_d[15:0] = sram_dq_i;
               cnt_d   = '0;
               state_d = S_HI;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HI: begin
            if (last_cyc) begin
               if (!op_wr_q) rd_data_d[31:16] = sram_dq_i;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      phase_d     = (state_d == S_LO) || (state_d == S_HI);
      sram_addr_d = sram_addr_q;
      dq_o_d      = dq_o_q;
      oe_d        = 1'b0;
      we_n_d      = 1'b1;
      if (phase_d) begin
         sram_addr_d = {word_d, (state_d == S_HI)};
         if (op_wr_d) begin
            oe_d   = 1'b1;
            // Strobe released on the last phase cycle so data is held past we_n rising.
            we_n_d = (cnt_d == CNT_LAST);
            dq_o_d = (state_d == S_HI) ? wdata_d[31:16] : wdata_d[15:0];
         end
      end
   end

   // State and output registers; async reset drops any strobe immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_wr_q     <= 1'b0;
         word_q      <= '0;
         wdata_q     <= '0;
         rd_data_q   <= '0;
         sram_addr_q <= '0;
         dq_o_q      <= '0;
         oe_q        <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_wr_q     <= op_wr_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         rd_data_q   <= rd_data_d;
         sram_addr_q <= sram_addr_d;
         dq_o_q      <= dq_o_d;
         oe_q        <= oe_d;
         we_n_q      <= we_n_d;
      end
   end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: a transaction-level reference model
// predicts every output per cycle from the request's age; a behavioural SRAM
// answers the pins. Directed cases pin the model with literal values.
module tb_sram_mem_ctrl;
   localparam int W    = 5;
   localparam int BASE = 1024;
`ifdef SRAM_ADDR_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_o;
   logic [15:0] sram_dq_i = 16'h0;
   logic        sram_dq_oe;
   logic        sram_we_n;

   sram_mem_ctrl_if bus ();

   sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .ADDR_W(18)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .sram_addr  (sram_addr),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_i  (sram_dq_i),
      .sram_dq_oe (sram_dq_oe),
      .sram_we_n  (sram_we_n)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int we_low_cnt = 0;
   int ready_cnt = 0;
   int last_ready_cyc = -1;

   logic [15:0] sram_arr [int];
   logic [31:0] ref_mem [int];

   bit          cur_active = 0;
   bit          cur_wr = 0;
   bit          cur_bad = 0;
   logic [16:0] cur_word = '0;
   logic [31:0] cur_data = '0;
   int          cur_k = 0;
   int          cur_lat = 0;
   logic [31:0] exp_rd = '0;

   bit exp_rdy, in_ph, hi;
   int pi;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] init16(input int a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] sram_rd(input int a);
      return sram_arr.exists(a) ? sram_arr[a] : init16(a);
   endfunction

   function automatic logic [31:0] ref_read(input logic [16:0] w);
      if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
      return {init16(int'({w, 1'b1})), init16(int'({w, 1'b0}))};
   endfunction

   task automatic preload(input logic [16:0] w, input logic [31:0] v);
      sram_arr[int'({w, 1'b0})] = v[15:0];
      sram_arr[int'({w, 1'b1})] = v[31:16];
      ref_mem[int'(w)] = v;
   endtask

   always @(posedge clk) cyc++;

   // Behavioural SRAM plus activity monitors.
   always @(negedge clk) begin
      if (rst_n && !sram_we_n) begin
         sram_arr[int'(sram_addr)] = sram_dq_o;
         we_low_cnt++;
      end
      sram_dq_i = sram_rd(int'(sram_addr));
      if (bus.ready === 1'b1) begin
         ready_cnt++;
         last_ready_cyc = cyc;
      end
   end

   // Compare process: expected outputs from the age of the current request.
   always @(negedge clk) begin
      if (!rst_n) begin
         cur_active = 0;
         exp_rd     = '0;
         chk("rst_ready", bus.ready, 0);
         chk("rst_rd_data", bus.rd_data, 0);
         chk("rst_sram_addr", sram_addr, 0);
         chk("rst_dq_o", sram_dq_o, 0);
         chk("rst_oe", sram_dq_oe, 0);
         chk("rst_we_n", sram_we_n, 1);
         chk("rst_freeze", bus.freeze, bus.mem_r_en | bus.mem_w_en);
      end else begin
         exp_rdy = cur_active && (cur_k == cur_lat);
         in_ph   = cur_active && !cur_bad && cur_k >= 1 && cur_k <= 2 * W;
         hi      = in_ph && (cur_k > W);
         pi      = hi ? cur_k - W - 1 : cur_k - 1;
         chk("ready", bus.ready, exp_rdy);
         chk("freeze", bus.freeze, (bus.mem_r_en | bus.mem_w_en) && !exp_rdy);
         chk("oe", sram_dq_oe, in_ph && cur_wr);
         chk("we_n", sram_we_n, !(in_ph && cur_wr && pi != W - 1));
         if (in_ph) begin
            chk("sram_addr", sram_addr, {cur_word, hi});
            if (cur_wr) chk("dq_o", sram_dq_o, hi ? cur_data[31:16] : cur_data[15:0]);
         end
         if (exp_rdy) begin
            if (cur_wr) begin
               if (!cur_bad) ref_mem[int'(cur_word)] = cur_data;
            end else begin
               exp_rd = cur_bad ? 32'h0 : ref_read(cur_word);
            end
            cur_active = 0;
         end
         if (!cur_active || cur_wr) chk("rd_data", bus.rd_data, exp_rd);
         cur_k++;
      end
   end

   // Starts an access in the current cycle (called just after a rising edge)
   // and returns just after the edge following the ready cycle.
   task automatic access(input bit wr, input bit both, input logic [31:0] a,
                         input logic [31:0] d, input int drop_at);
      logic [31:0] dv;
      logic [31:0] wv;
      dv = a - BASE;
      wv = dv >> 2;
      bus.mem_w_en = wr;
      bus.mem_r_en = !wr || both;
      bus.addr     = a;
      bus.wr_data  = d;
      cur_wr   = wr;
      cur_word = wv[16:0];
      cur_data = d;
      cur_bad  = CHECK && (a < BASE || wv >= 32'h20000);
      cur_lat  = cur_bad ? 1 : 2 * W + 1;
      cur_k    = 0;
      cur_active = 1;
      for (int i = 1; i <= cur_lat; i++) begin
         @(posedge clk); #1;
         if (i == drop_at) begin
            bus.mem_w_en = 1'b0;
            bus.mem_r_en = 1'b0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bus.mem_w_en = 1'b0;
      bus.mem_r_en = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   int          t0, rc0;
   logic [31:0] rv, ra;
   bit          rwr;
   int          gap, drop;

   initial begin
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
      bus.addr     = '0;
      bus.wr_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      chk("reset_we_n_lit", sram_we_n, 1);
      chk("reset_freeze_lit", bus.freeze, 0);

      // Directed write of DEADBEEF at word 2 (SRAM halfwords 4/5).
      we_low_cnt = 0;
      t0 = cyc;
      access(1, 0, BASE + 8, 32'hDEADBEEF, 0);
      chk("wr_lat_lit", last_ready_cyc - t0, 2 * W + 1);
      chk("wr_lo_lit", sram_rd(4), 16'hBEEF);
      chk("wr_hi_lit", sram_rd(5), 16'hDEAD);
      chk("wr_we_low_lit", we_low_cnt, 2 * (W - 1));
      idle(2);

      // Directed read with SRAM holding 1234/ABCD at halfwords 4/5.
      preload(17'd2, 32'hABCD1234);
      t0 = cyc;
      access(0, 0, 1032, 32'h0, 0);
      chk("rd_lat_lit", last_ready_cyc - t0, 2 * W + 1);
      chk("rd_data_lit", bus.rd_data, 32'hABCD1234);
      idle(2);

      // Back-to-back write then read of the same word.
      t0 = cyc;
      access(1, 0, 1032, 32'h0BAD_F00D, 0);
      access(0, 0, 1032, 32'h0, 0);
      chk("b2b_total_lit", last_ready_cyc - t0, 4 * W + 3);
      chk("b2b_data_lit", bus.rd_data, 32'h0BAD_F00D);
      idle(1);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         rwr = $urandom_range(0, 1);
         rv  = $urandom;
         case ($urandom_range(0, 7))
            0:       ra = BASE + (32'h20000 + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3);
            1:       ra = $urandom_range(0, BASE - 1);
            default: ra = BASE + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
         endcase
         drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2 * W) : 0;
         if (CHECK && (ra < BASE || ((ra - BASE) >> 2) >= 32'h20000)) drop = 0;
         gap = $urandom_range(0, 2);
         if (gap != 0) idle(gap);
         access(rwr, $urandom_range(0, 1), ra, rv, drop);
      end
      idle(2);

      // Reset asserted in cycle 3 of a write.
      bus.mem_w_en = 1'b1;
      bus.mem_r_en = 1'b0;
      bus.addr     = BASE + 400;
      bus.wr_data  = 32'h5555AAAA;
      cur_wr = 1; cur_bad = 0; cur_word = 17'd100; cur_data = 32'h5555AAAA;
      cur_lat = 2 * W + 1; cur_k = 0; cur_active = 1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("abort_we_n_lit", sram_we_n, 1);
      chk("abort_oe_lit", sram_dq_oe, 0);
      chk("abort_ready_lit", bus.ready, 0);
      bus.mem_w_en = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      rc0 = ready_cnt;
      idle(2 * W + 4);
      chk("abort_no_ready_lit", ready_cnt - rc0, 0);

`ifdef SRAM_ADDR_CHECK_EN
      // Out-of-window read completes in one cycle with no SRAM activity.
      we_low_cnt = 0;
      t0 = cyc;
      access(0, 0, 16, 32'h0, 0);
      chk("chk_lat_lit", last_ready_cyc - t0, 1);
      chk("chk_rd_lit", bus.rd_data, 0);
      chk("chk_we_lit", we_low_cnt, 0);
      idle(2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
